// File: rtl/memory_array_pkg.sv
// -----------------------------------------------------------------------------
// memory_array_pkg
// Shared constants and helpers for the in-memory-compute storage slice.
//   DEFAULT_WIDTH : number of cells in each of the D and R vectors
//   d_op_t        : decoded parallel operation on the D vector
//   decode_d_op   : maps GWL/READ/Write onto the parallel operation
// -----------------------------------------------------------------------------
package memory_array_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Decoded parallel access to D. A simultaneous read and write is a
    // distinct case because DataOut must capture D before it is overwritten.
    typedef enum logic [1:0] {
        D_OP_NONE  = 2'b00,
        D_OP_READ  = 2'b01,
        D_OP_WRITE = 2'b10,
        D_OP_RMW   = 2'b11
    } d_op_t;

    // The global word line gates both parallel strobes; without it the
    // column is isolated from the parallel bus.
    function automatic d_op_t decode_d_op(input logic gwl,
                                          input logic read,
                                          input logic write);
        d_op_t op;
        op = D_OP_NONE;
        if (gwl) begin
            unique case ({write, read})
                2'b01:   op = D_OP_READ;
                2'b10:   op = D_OP_WRITE;
                2'b11:   op = D_OP_RMW;
                default: op = D_OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/memory_array_result_col.sv
// -----------------------------------------------------------------------------
// memory_array_result_col
// Bit-serial result column (R cells) of the storage slice.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, clears every R cell
//   clr        : clear all R cells; wins over any write word line
//   wwl        : per-cell write word lines; selected cells take from_adder
//   from_adder : serial result bit from the adder
//   rwl        : per-cell read word lines
//   to_adder   : wired-OR of the selected R cells (combinational)
// -----------------------------------------------------------------------------
module memory_array_result_col
    import memory_array_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] wwl,
    input  logic             from_adder,
    input  logic [WIDTH-1:0] rwl,
    output logic             to_adder
);

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] r_sel;

    // Per-cell next-state: every cell sees the same serial bit, its own
    // write word line decides whether it captures it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign r_next[gi] = clr     ? 1'b0       :
                                wwl[gi] ? from_adder :
                                          r_reg[gi];
            assign r_sel[gi]  = rwl[gi] & r_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg <= '0;
        end else begin
            r_reg <= r_next;
        end
    end

    // Shared read bit line: any selected cell holding 1 pulls it high.
    assign to_adder = |r_sel;

endmodule

// File: rtl/memory_array.sv
// -----------------------------------------------------------------------------
// memory_array
// Single-column in-memory-compute storage slice for the convolution engine.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (D, R and DataOut to zero)
//   DataIn    : parallel operand vector written into D
//   RWL       : read word lines, one per R cell
//   GWL       : global word line, enables parallel D access
//   WWL       : write word lines, one per R cell
//   READ      : parallel read of D into DataOut (qualified by GWL)
//   Write     : parallel write of DataIn into D (qualified by GWL)
//   Clr       : clear R cells
//   FromAdder : serial result bit from the adder
//   DataOut   : registered parallel read-out of D (1-cycle latency)
//   ToAdder   : serial bit of R returned to the adder
// The D side and the R side share only clock and reset.
// -----------------------------------------------------------------------------
module memory_array
    import memory_array_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [WIDTH-1:0] RWL,
    input  logic             GWL,
    input  logic [WIDTH-1:0] WWL,
    input  logic             READ,
    input  logic             Write,
    input  logic             Clr,
    input  logic             FromAdder,
    output logic [WIDTH-1:0] DataOut,
    output logic             ToAdder
);

    d_op_t            d_op;
    logic             d_load;
    logic             out_load;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] data_out_reg;
    logic [WIDTH-1:0] data_out_next;

    assign d_op     = decode_d_op(GWL, READ, Write);
    assign d_load   = (d_op == D_OP_WRITE) || (d_op == D_OP_RMW);
    assign out_load = (d_op == D_OP_READ)  || (d_op == D_OP_RMW);

    // DataOut is fed from the current d_reg, never from d_next, so a
    // combined read/write returns the value stored before this edge.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_d_cell
            assign d_next[gi]        = d_load   ? DataIn[gi] : d_reg[gi];
            assign data_out_next[gi] = out_load ? d_reg[gi]  : data_out_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg        <= '0;
            data_out_reg <= '0;
        end else begin
            d_reg        <= d_next;
            data_out_reg <= data_out_next;
        end
    end

    assign DataOut = data_out_reg;

    memory_array_result_col #(
        .WIDTH (WIDTH)
    ) u_result_col (
        .clk        (clk),
        .rst        (rst),
        .clr        (Clr),
        .wwl        (WWL),
        .from_adder (FromAdder),
        .rwl        (RWL),
        .to_adder   (ToAdder)
    );

endmodule

// File: tb/tb_memory_array.sv
// -----------------------------------------------------------------------------
// tb_memory_array
// Directed and randomized stimulus against a behavioural model of the
// D/R storage slice.
// -----------------------------------------------------------------------------
module tb_memory_array;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] DataIn;
    logic [W-1:0] RWL;
    logic         GWL;
    logic [W-1:0] WWL;
    logic         READ;
    logic         Write;
    logic         Clr;
    logic         FromAdder;
    logic [W-1:0] DataOut;
    logic         ToAdder;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0] d_m;
    logic [W-1:0] r_m;
    logic [W-1:0] dout_m;

    memory_array #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .DataIn    (DataIn),
        .RWL       (RWL),
        .GWL       (GWL),
        .WWL       (WWL),
        .READ      (READ),
        .Write     (Write),
        .Clr       (Clr),
        .FromAdder (FromAdder),
        .DataOut   (DataOut),
        .ToAdder   (ToAdder)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst       = 1'b0;
        DataIn    = '0;
        RWL       = '0;
        GWL       = 1'b0;
        WWL       = '0;
        READ      = 1'b0;
        Write     = 1'b0;
        Clr       = 1'b0;
        FromAdder = 1'b0;
    endtask

    // Apply the behavioural rules for one rising edge, then advance.
    task automatic tick();
        logic [W-1:0] old_d;
        old_d = d_m;
        if (rst) begin
            d_m = '0; r_m = '0; dout_m = '0;
        end else begin
            if (GWL && READ)  dout_m = old_d;
            if (GWL && Write) d_m = DataIn;
            if (Clr) r_m = '0;
            else begin
                for (int i = 0; i < W; i++)
                    if (WWL[i]) r_m[i] = FromAdder;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_to_adder(input logic [W-1:0] rwl);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < W; j++)
            if (rwl[j] && r_m[j]) hit = 1'b1;
        return hit;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read R back bit-serially through one-hot RWL
    task automatic collect_r(output logic [W-1:0] val);
        for (int j = 0; j < W; j++) begin
            RWL = W'(1) << j;
            #1;
            val[j] = ToAdder;
        end
        RWL = '0;
        #1;
    endtask

    task automatic parallel_write(input logic [W-1:0] v);
        idle(); GWL = 1'b1; Write = 1'b1; DataIn = v; tick(); idle();
    endtask

    task automatic parallel_read();
        idle(); GWL = 1'b1; READ = 1'b1; tick(); idle();
    endtask

    initial begin
        logic [W-1:0] got;
        d_m = 'x; r_m = 'x; dout_m = 'x;

        // 1. Reset with random inputs
        idle();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            DataIn = W'($urandom); RWL = W'($urandom); WWL = W'($urandom);
            GWL = 1'($urandom); READ = 1'($urandom); Write = 1'($urandom);
            Clr = 1'($urandom); FromAdder = 1'($urandom);
            tick();
        end
        idle();
        #1;
        check("reset_dataout", 32'(DataOut), 32'h00);
        for (int k = 0; k < 4; k++) begin
            RWL = W'($urandom) | W'(1) << k;
            #1;
            check("reset_toadder", 32'(ToAdder), 32'h0);
        end
        idle();

        // 2. Parallel write/read, GWL gating
        parallel_write(8'hFF);
        idle(); GWL = 1'b1; READ = 1'b1; DataIn = 8'h00; tick(); idle();
        check("pread_ff", 32'(DataOut), 32'hFF);
        idle(); GWL = 1'b0; Write = 1'b1; DataIn = 8'h00; tick(); idle();
        parallel_read();
        check("gwl_block", 32'(DataOut), 32'hFF);

        // Read latency: DataOut must not change before the edge
        parallel_write(8'h5A);
        idle(); GWL = 1'b1; READ = 1'b1; #1;
        check("latency_pre", 32'(DataOut), 32'hFF);
        tick(); idle();
        check("latency_post", 32'(DataOut), 32'h5A);

        // 3. Read-before-write
        parallel_write(8'hA5);
        idle(); GWL = 1'b1; READ = 1'b1; Write = 1'b1; DataIn = 8'h3C; tick(); idle();
        check("rbw_old", 32'(DataOut), 32'hA5);
        parallel_read();
        check("rbw_new", 32'(DataOut), 32'h3C);

        // 4. Serial write/read
        idle(); Clr = 1'b1; tick(); idle();
        for (int i = 0; i < W; i++) begin
            WWL = W'(1) << i;
            FromAdder = (8'h55 >> i) & 1'b1;
            tick();
        end
        idle();
        collect_r(got);
        check("serial_55", 32'(got), 32'h55);
        RWL = '0; #1;
        check("rwl_zero", 32'(ToAdder), 32'h0);

        // 5. Clear priority over WWL
        idle(); WWL = 8'hFF; FromAdder = 1'b1; tick(); idle();
        collect_r(got);
        check("r_all_ones", 32'(got), 32'hFF);
        idle(); Clr = 1'b1; WWL = 8'h01; FromAdder = 1'b1; tick(); idle();
        RWL = 8'h01; #1;
        check("clr_priority", 32'(ToAdder), 32'h0);
        RWL = '0;
        check("clr_keeps_dout", 32'(DataOut), 32'h3C);
        parallel_read();
        check("clr_keeps_d", 32'(DataOut), 32'h3C);

        // 6. Multi-select and independence
        idle(); Clr = 1'b1; tick(); idle();
        WWL = 8'hF0; FromAdder = 1'b1; GWL = 1'b1; Write = 1'b1; DataIn = 8'h12;
        tick(); idle();
        RWL = 8'h0F; #1;
        check("multi_rwl_0f", 32'(ToAdder), 32'h0);
        RWL = 8'h81; #1;
        check("multi_rwl_81", 32'(ToAdder), 32'h1);
        RWL = '0;
        collect_r(got);
        check("multi_r_f0", 32'(got), 32'hF0);
        parallel_read();
        check("indep_d_12", 32'(DataOut), 32'h12);

        // Mid-operation reset
        idle(); rst = 1'b1; GWL = 1'b1; Write = 1'b1; READ = 1'b1; DataIn = 8'hEE;
        WWL = 8'hFF; FromAdder = 1'b1; tick(); idle();
        check("midrst_dout", 32'(DataOut), 32'h00);
        collect_r(got);
        check("midrst_r", 32'(got), 32'h00);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            rst       = ($urandom_range(0, 31) == 0);
            DataIn    = W'($urandom);
            GWL       = 1'($urandom);
            READ      = 1'($urandom);
            Write     = 1'($urandom);
            Clr       = ($urandom_range(0, 7) == 0);
            WWL       = W'($urandom) & W'($urandom);
            FromAdder = 1'($urandom);
            RWL       = '0;
            tick();
            idle();
            check("rand_dataout", 32'(DataOut), 32'(dout_m));
            RWL = W'($urandom) & W'($urandom);
            #1;
            check("rand_toadder", 32'(ToAdder), 32'(model_to_adder(RWL)));
            RWL = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
